// File: rtl/io_port_ctrl.sv
// ---------------------------------------------------------------------------
// io_port_ctrl
//
// Processor-facing I/O port block. NUIOIN producer channels each feed a small
// FIFO that the processor drains one word per read strobe. NUIOOU output
// registers are written by the processor and drained by consumers through a
// valid/ready handshake. Sticky flags record reads of empty FIFOs and writes
// to busy output registers.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   proc_req_in     processor read strobe for channel addr_in
//   addr_in         input channel selected for reading
//   proc_in         combinational head of FIFO[addr_in] (0 when empty)
//   proc_out_en     processor write strobe for channel addr_out
//   addr_out        output channel selected for writing
//   proc_out        processor write data
//   ch_in_*         producer side (data packed NUBITS per channel)
//   ch_out_*        consumer side (data packed NUBITS per channel)
//   clr_flags       clears in_underflow / out_overflow
//   in_underflow    sticky: a read hit an empty FIFO
//   out_overflow    sticky: a write hit a busy output register
// ---------------------------------------------------------------------------
module io_port_ctrl #(
    parameter int NUBITS = 31,
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4,
    parameter int IDEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       proc_req_in,
    input  logic [1:0]                 addr_in,
    output logic [NUBITS-1:0]          proc_in,
    input  logic                       proc_out_en,
    input  logic [1:0]                 addr_out,
    input  logic [NUBITS-1:0]          proc_out,
    input  logic [NUIOIN*NUBITS-1:0]   ch_in_data,
    input  logic [NUIOIN-1:0]          ch_in_valid,
    output logic [NUIOIN-1:0]          ch_in_ready,
    output logic [NUIOOU*NUBITS-1:0]   ch_out_data,
    output logic [NUIOOU-1:0]          ch_out_valid,
    input  logic [NUIOOU-1:0]          ch_out_ready,
    input  logic                       clr_flags,
    output logic [NUIOIN-1:0]          in_underflow,
    output logic [NUIOOU-1:0]          out_overflow
);

    // Pointer width; IDEPTH is a power of two so pointers wrap naturally.
    localparam int PW = (IDEPTH > 1) ? $clog2(IDEPTH) : 1;
    // Occupancy must represent 0..IDEPTH inclusive.
    localparam int CW = $clog2(IDEPTH + 1);

    logic [NUBITS-1:0] head_w [NUIOIN];
    logic [NUIOIN-1:0] empty_w;
    logic [NUIOIN-1:0] uf_evt_w;
    logic [NUIOOU-1:0] of_evt_w;

    logic [NUIOIN-1:0] in_underflow_q, in_underflow_d;
    logic [NUIOOU-1:0] out_overflow_q, out_overflow_d;

    // -----------------------------------------------------------------------
    // Input FIFOs
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_in
        logic [NUBITS-1:0] mem_q [IDEPTH];
        logic [NUBITS-1:0] mem_d [IDEPTH];
        logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]     count_q, count_d;
        logic              full, empty, sel, push, pop;

        assign full  = (count_q == CW'(IDEPTH));
        assign empty = (count_q == '0);
        assign sel   = proc_req_in && (addr_in == 2'(gi));
        // Ready comes only from registered occupancy, so a full FIFO refuses
        // a push even when the processor pops it in the same cycle.
        assign push  = ch_in_valid[gi] && !full;
        assign pop   = sel && !empty;

        assign ch_in_ready[gi] = !full;
        assign head_w[gi]      = mem_q[rd_ptr_q];
        assign empty_w[gi]     = empty;
        assign uf_evt_w[gi]    = sel && empty;

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push) begin
                mem_d[wr_ptr_q] = ch_in_data[gi*NUBITS +: NUBITS];
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Storage carries no reset: emptiness is tracked by count/pointers.
        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end
    end

    // Head of the selected FIFO; an empty FIFO reads as zero so a same-cycle
    // push never bypasses to the processor.
    always_comb begin
        proc_in = '0;
        if (!empty_w[addr_in]) begin
            proc_in = head_w[addr_in];
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUIOOU; gi++) begin : g_out
        logic              valid_q, valid_d;
        logic [NUBITS-1:0] data_q, data_d;
        logic              hit, accept;

        assign hit    = proc_out_en && (addr_out == 2'(gi));
        // Load allowed when empty or when the consumer drains this cycle.
        assign accept = hit && (!valid_q || ch_out_ready[gi]);

        assign of_evt_w[gi]                       = hit && valid_q && !ch_out_ready[gi];
        assign ch_out_valid[gi]                   = valid_q;
        assign ch_out_data[gi*NUBITS +: NUBITS]   = data_q;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (accept) begin
                valid_d = 1'b1;
                data_d  = proc_out;
            end else if (valid_q && ch_out_ready[gi]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sticky flags: a new event in the clear cycle wins over the clear.
    // -----------------------------------------------------------------------
    always_comb begin
        in_underflow_d = uf_evt_w | (in_underflow_q & {NUIOIN{!clr_flags}});
        out_overflow_d = of_evt_w | (out_overflow_q & {NUIOOU{!clr_flags}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_underflow_q <= '0;
            out_overflow_q <= '0;
        end else begin
            in_underflow_q <= in_underflow_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign in_underflow = in_underflow_q;
    assign out_overflow = out_overflow_q;

endmodule
